reg_file_flags: RTL
===================

// Module: reg_file_flags
// PURPOSE
// - Architectural state stage feeding the 8-bit ALU: register file supplying operands inA/inB and
//   capturing ALU rslt at writeback; status register latching ALU sc_o/zero/pari/equal.
// - Latched carry is returned to the ALU as sc_i, enabling multi-byte add/shift chains.
// - Latched equal is exported to the fetch stage for branch resolution.
// PARAMETERS
// - DW   8  data width of each register and of the ALU datapath
// - AW   3  register address width; NREGS = 2**AW entries
// PORTS
// - clk        in   1   rising-edge clock
// - reset      in   1   asynchronous, active-high reset
// - rd_addr_a  in   AW  read port A address
// - rd_addr_b  in   AW  read port B address
// - data_a     out  DW  register[rd_addr_a]; drives ALU inA
// - data_b     out  DW  register[rd_addr_b]; drives ALU inB
// - wr_en      in   1   write strobe for register file
// - wr_addr    in   AW  write address
// - wr_data    in   DW  write data (ALU rslt)
// - flag_we    in   1   latch ALU flags this cycle
// - sc_in      in   1   ALU sc_o
// - zero_in    in   1   ALU zero
// - pari_in    in   1   ALU pari
// - equal_in   in   1   ALU equal
// - carry_clr  in   1   force carry flag to 0 (start of a new multi-byte chain)
// - sc_out     out  1   latched carry; drives ALU sc_i
// - flags      out  4   {equal, pari, zero, carry} latched status
// BEHAVIOUR
// - Reset: asserting reset immediately clears all NREGS registers and flags to 0; data_a/data_b read 0,
//   sc_out=0, flags=4'b0000. Reset mid-write discards the write. Reset dominates all inputs.
// - Reads: combinational, zero latency; data_a/data_b follow address changes in the same cycle.
// - Write: on rising clk edge with wr_en=1, register[wr_addr] <= wr_data. Visible on reads the
//   following cycle. wr_en=0: no register changes. All addresses 0..NREGS-1 writable; no hardwired zero.
// - Flags: on rising edge with flag_we=1, {equal,pari,zero,carry} <= {equal_in,pari_in,zero_in,sc_in};
//   flag_we=0 holds all four.
// - carry_clr=1 at an edge forces carry <= 0, overriding sc_in even when flag_we=1; other three flags
//   still update per flag_we.
// - sc_out == flags[0] at all times (same flop, no extra latency).
// - Write and flag update are independent; both may occur in the same cycle.
// - Same-cycle read/write of one address: governed by REG_FILE_BYPASS_EN (below).
// - Both read ports may address the same register; both return the same value.
// CONFIGURATION
// - REG_FILE_BYPASS_EN defined: when wr_en=1 and rd_addr_x==wr_addr, data_x returns wr_data
//   combinationally in that cycle (write-through). Applies independently to ports A and B.
// - REG_FILE_BYPASS_EN undefined: data_x returns the pre-write stored value in that cycle; new value
//   visible from the next cycle.
// TESTING
// - Reset: pulse reset async between edges -> all reads 0, flags=0000, sc_out=0 without waiting for clk.
// - Write/read: wr r3<=8'hA5, next cycle rd_addr_a=3,rd_addr_b=3 -> data_a=data_b=8'hA5; r4 still 0.
// - Same-cycle hazard: r2=8'h11, write r2<=8'h22 with rd_addr_a=2 -> data_a=8'h22 with
//   REG_FILE_BYPASS_EN, 8'h11 without; next cycle 8'h22 in both builds.
// - Carry chain: flag_we=1,sc_in=1 -> sc_out=1 next cycle; flag_we=0 for 3 cycles -> sc_out stays 1;
//   then carry_clr=1,flag_we=1,sc_in=1,zero_in=1 -> flags=4'b0010.
// - Flag capture: flag_we=1 with {equal,pari,zero,sc}=1,0,1,0 -> flags=4'b1010; flag_we=0 with
//   inputs toggled -> flags hold 4'b1010.
// - Reset mid-operation: wr_en=1 r7<=8'hFF with reset asserted across the edge -> r7 reads 0 after release.

Source files
------------

// File: rtl/reg_file_flags.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_flags
// Description : Architectural state stage for the 8-bit ALU. A register file
//               with two combinational read ports (ALU inA/inB) and one write
//               port (ALU rslt), plus a status register latching the ALU
//               flags {equal, pari, zero, carry}. The latched carry is
//               returned to the ALU as sc_out for multi-byte chains.
// Config      : define REG_FILE_BYPASS_EN for write-through reads when a read
//               address matches the active write address in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_flags #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          flag_we,
  input  logic          sc_in,
  input  logic          zero_in,
  input  logic          pari_in,
  input  logic          equal_in,
  input  logic          carry_clr,
  output logic          sc_out,
  output logic [3:0]    flags
);

  localparam int NREGS = 2 ** AW;

  logic [DW-1:0] r_regs [NREGS];
  logic          r_carry;
  logic          r_zero;
  logic          r_pari;
  logic          r_equal;

  logic [DW-1:0] w_stored_a;
  logic [DW-1:0] w_stored_b;

  // Register file storage: cleared by reset, otherwise one write per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Status flags: carry_clr overrides the captured carry but not the others
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_pari  <= 1'b0;
      r_equal <= 1'b0;
    end else begin
      if (flag_we) begin
        r_zero  <= zero_in;
        r_pari  <= pari_in;
        r_equal <= equal_in;
      end
      if (carry_clr) begin
        r_carry <= 1'b0;
      end else if (flag_we) begin
        r_carry <= sc_in;
      end
    end
  end

  assign w_stored_a = r_regs[rd_addr_a];
  assign w_stored_b = r_regs[rd_addr_b];

`ifdef REG_FILE_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;

  assign w_byp_a = wr_en && (rd_addr_a == wr_addr);
  assign w_byp_b = wr_en && (rd_addr_b == wr_addr);

  // Write-through read ports: an in-flight write is forwarded to a matching reader
  always_comb begin
    data_a = w_byp_a ? wr_data : w_stored_a;
    data_b = w_byp_b ? wr_data : w_stored_b;
  end
`else
  // Plain read ports: a same-cycle write becomes visible only after the edge
  always_comb begin
    data_a = w_stored_a;
    data_b = w_stored_b;
  end
`endif

  // sc_out is the carry flop itself, so the ALU sees no extra latency
  assign sc_out = r_carry;
  assign flags  = {r_equal, r_pari, r_zero, r_carry};

endmodule
`default_nettype wire
